// File: rtl/hazard_pkg.sv
// Shared forwarding codes, Tuse sentinel and default MDU latencies for the
// hazard scoreboard.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam int TNEW_W_DEF = 2;
    localparam logic [TNEW_W_DEF-1:0] TNEW_UNUSED = '1;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide occupancy counter: loaded when a mult/div leaves E,
// then counts down to idle.
module md_busy_ctr #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [CW-1:0] cnt;

    // A fresh start always reloads, even over a running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: tracks E/M/W destinations and Tnew internally.
// Define HAZARD_WB_BYPASS_EN to allow W bypass on the D-stage selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int TNEW_W  = TNEW_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              d_md_start,
    input  logic              d_md_div,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic [1:0]        fwd_m_rt,
    output logic              md_busy
);

    logic [REG_AW-1:0] e_dst, e_rs, e_rt, m_dst, m_rt, w_dst;
    logic [TNEW_W-1:0] e_tnew, m_tnew;
    logic              e_md_start, e_md_div;
    logic              ctr_busy;

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Producer still ahead of the consumer's need point.
    function automatic logic src_hazard(input logic [REG_AW-1:0] src,
                                        input logic [TNEW_W-1:0] tuse);
        return (src != '0) &&
               (((e_dst == src) && (e_tnew > tuse)) ||
                ((m_dst == src) && (m_tnew > tuse)));
    endfunction

    // Nearest matching producer wins; if it is not ready the stall covers it.
    function automatic logic [1:0] fwd_d_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (e_dst == src)
                sel = (e_tnew == '0) ? FWD_E : FWD_RF;
            else if (m_dst == src)
                sel = (m_tnew == '0) ? FWD_M : FWD_RF;
`ifdef HAZARD_WB_BYPASS_EN
            else if (w_dst == src)
                sel = FWD_W;
`endif
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (m_dst == src)
                sel = (m_tnew == '0) ? FWD_M : FWD_RF;
            else if (w_dst == src)
                sel = FWD_W;
        end
        return sel;
    endfunction

    assign md_busy  = ctr_busy | e_md_start;
    assign stall    = src_hazard(d_rs, d_tuse_rs) | src_hazard(d_rt, d_tuse_rt) |
                      (d_md_use & md_busy);
    assign fwd_d_rs = fwd_d_sel(d_rs);
    assign fwd_d_rt = fwd_d_sel(d_rt);
    assign fwd_e_rs = fwd_e_sel(e_rs);
    assign fwd_e_rt = fwd_e_sel(e_rt);
    assign fwd_m_rt = ((m_rt != '0) && (w_dst == m_rt)) ? FWD_W : FWD_RF;

    // M and W advance unconditionally; only E takes the bubble on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dst      <= '0;
            e_tnew     <= '0;
            e_rs       <= '0;
            e_rt       <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_dst      <= '0;
            m_tnew     <= '0;
            m_rt       <= '0;
            w_dst      <= '0;
        end else begin
            m_dst  <= e_dst;
            m_tnew <= tnew_dec(e_tnew);
            m_rt   <= e_rt;
            w_dst  <= m_dst;
            if (!stall && d_valid) begin
                e_dst      <= d_dst;
                e_tnew     <= d_tnew;
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_md_start <= d_md_start;
                e_md_div   <= d_md_start & d_md_div;
            end else begin
                e_dst      <= '0;
                e_tnew     <= '0;
                e_rs       <= '0;
                e_rt       <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end
        end
    end

    md_busy_ctr #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .start (e_md_start),
        .div   (e_md_div),
        .busy  (ctr_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed stall/forward values.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_valid = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic [1:0] d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
    logic       d_md_use = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_md_use   (d_md_use),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt),
        .md_busy    (md_busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] tuse_rs,
                         input logic [4:0] rt, input logic [1:0] tuse_rt,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic md_use, input logic md_start, input logic md_div);
        d_valid = 1'b1;
        d_rs = rs; d_tuse_rs = tuse_rs;
        d_rt = rt; d_tuse_rt = tuse_rt;
        d_dst = dst; d_tnew = tnew;
        d_md_use = md_use; d_md_start = md_start; d_md_div = md_div;
        #1;
    endtask

    task automatic clr_d();
        d_valid = 1'b0;
        d_rs = '0; d_rt = '0; d_dst = '0; d_tnew = '0;
        d_tuse_rs = TNEW_UNUSED; d_tuse_rt = TNEW_UNUSED;
        d_md_use = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
        #1;
    endtask

    task automatic flush();
        clr_d();
        repeat (4) tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall"}, int'(stall), 0);
        chk({tag, ".fwd_d_rs"}, int'(fwd_d_rs), 0);
        chk({tag, ".fwd_d_rt"}, int'(fwd_d_rt), 0);
        chk({tag, ".fwd_e_rs"}, int'(fwd_e_rs), 0);
        chk({tag, ".fwd_e_rt"}, int'(fwd_e_rt), 0);
        chk({tag, ".fwd_m_rt"}, int'(fwd_m_rt), 0);
        chk({tag, ".md_busy"}, int'(md_busy), 0);
    endtask

    int n;

    initial begin
        // Reset state ignores hostile D inputs.
        set_d(5'd3, 2'd0, 5'd3, 2'd0, 5'd3, 2'd1, 1'b1, 1'b1, 1'b1);
        #2;
        chk_quiet("reset");
        clr_d();
        tick();
        rst_n = 1'b1;
        tick();

        // ALU RAW: producer tnew 1, consumer tuse 0.
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("raw.first_no_stall", int'(stall), 0);
        tick();
        set_d(5'd3, 2'd0, 5'd4, TNEW_UNUSED, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("raw.stall", int'(stall), 1);
        chk("raw.fwd_d_rs_pending", int'(fwd_d_rs), 0);
        tick();
        chk("raw.stall_released", int'(stall), 0);
        chk("raw.fwd_d_rs_m", int'(fwd_d_rs), 2);
        tick();
        clr_d();
        chk("raw.fwd_e_rs_w", int'(fwd_e_rs), 3);
        chk("raw.fwd_e_rt_none", int'(fwd_e_rt), 0);
        flush();

        // Load-use: lw tnew 2, ALU tuse 1.
        set_d(5'd1, 2'd1, 5'd0, TNEW_UNUSED, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd5, 2'd1, 5'd0, TNEW_UNUSED, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("lu.stall", int'(stall), 1);
        tick();
        chk("lu.stall_released", int'(stall), 0);
        chk("lu.fwd_d_rs_not_ready", int'(fwd_d_rs), 0);
        tick();
        set_d(5'd5, 2'd0, 5'd0, TNEW_UNUSED, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lu.fwd_e_rs_w", int'(fwd_e_rs), 3);
`ifdef HAZARD_WB_BYPASS_EN
        chk("lu.fwd_d_rs_wb", int'(fwd_d_rs), 3);
`else
        chk("lu.fwd_d_rs_wb", int'(fwd_d_rs), 0);
`endif
        flush();

        // jal then jr $31.
        set_d(5'd0, TNEW_UNUSED, 5'd0, TNEW_UNUSED, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 2'd0, 5'd0, TNEW_UNUSED, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("jal.stall", int'(stall), 0);
        chk("jal.fwd_d_rs_e", int'(fwd_d_rs), 1);
        flush();

        // Divide in E, mflo in D: stall for DIV_LAT+1 = 11 cycles.
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        chk("div.idle_busy", int'(md_busy), 0);
        chk("div.no_stall", int'(stall), 0);
        tick();
        set_d(5'd0, TNEW_UNUSED, 5'd0, TNEW_UNUSED, 5'd9, 2'd1, 1'b1, 1'b0, 1'b0);
        chk("div.busy_in_e", int'(md_busy), 1);
        n = 0;
        while (stall && n < 40) begin
            n++;
            tick();
        end
        chk("div.stall_cycles", n, 11);
        chk("div.busy_after", int'(md_busy), 0);
        flush();

        // Multiply: md_busy high MUL_LAT+1 = 6 cycles.
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        clr_d();
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            tick();
        end
        chk("mul.busy_cycles", n, 6);
        flush();

        // Register zero never hazards.
        set_d(5'd1, 2'd1, 5'd0, TNEW_UNUSED, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("r0.stall", int'(stall), 0);
        chk("r0.fwd_d_rs", int'(fwd_d_rs), 0);
        chk("r0.fwd_d_rt", int'(fwd_d_rt), 0);
        flush();

        // Store data: producer $7 then sw rt=$7 reaching M while $7 is in W.
        set_d(5'd1, 2'd1, 5'd0, TNEW_UNUSED, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("sw.stall", int'(stall), 0);
        tick();
        clr_d();
        chk("sw.fwd_e_rt_m", int'(fwd_e_rt), 2);
        tick();
        chk("sw.fwd_m_rt_w", int'(fwd_m_rt), 3);
        flush();

        // Reset mid-stream with mult busy and E occupied.
        set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd10, 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(5'd1, 2'd1, 5'd0, TNEW_UNUSED, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd11, 2'd0, 5'd0, TNEW_UNUSED, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
        chk("rst.pre_stall", int'(stall), 1);
        chk("rst.pre_busy", int'(md_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("rst.async");
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst.after_stall", int'(stall), 0);
        chk("rst.after_fwd", int'(fwd_d_rs), 0);
        flush();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
